// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response bundle between the MEM stage and dmem_lsu
interface dmem_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - little-endian byte data memory with registered response; DMEM_WAIT_STATE_EN adds wait states
module dmem_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_lsu_if.slave   bus
);
  localparam int NB    = XLEN / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept;
  logic [3:0]      nbytes;
  logic [6:0]      nbits;
  logic            misalign;
  logic            illegal;
  logic            err;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] topbit;
  logic [XLEN-1:0] ext;

  assign accept = (state_q == IDLE) && bus.req_valid;

  always_comb begin
    nbytes   = 4'd1;
    nbits    = 7'd8;
    misalign = 1'b0;
    case (bus.req_size)
      2'b00: begin nbytes = 4'd1; nbits = 7'd8;  misalign = 1'b0; end
      2'b01: begin nbytes = 4'd2; nbits = 7'd16; misalign = bus.req_addr[0]; end
      2'b10: begin nbytes = 4'd4; nbits = 7'd32; misalign = |bus.req_addr[1:0]; end
      default: begin nbytes = 4'd8; nbits = 7'd64; misalign = |bus.req_addr[2:0]; end
    endcase
  end

  assign illegal = (bus.req_size == 2'b11) && (XLEN == 32);
  assign err     = illegal || misalign;

  // Bytes past the access size are fetched too; the mask below trims them.
  always_comb begin
    raw = '0;
    for (int b = 0; b < NB; b++) begin
      raw[8*b +: 8] = mem[bus.req_addr + ADDR_W'(b)];
    end
  end

  // Sign bit is the top bit of the masked field, so no variable index is needed.
  always_comb begin
    mask   = (int'(nbits) >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    topbit = mask & ~(mask >> 1);
    ext    = raw & mask;
    if (!bus.req_unsigned && |(raw & topbit)) begin
      ext = ext | ~mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (accept && bus.req_we && !err) begin
      for (int b = 0; b < NB; b++) begin
        if (4'(b) < nbytes) begin
          mem[bus.req_addr + ADDR_W'(b)] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= err;
      rdata_q <= (bus.req_we || err) ? '0 : ext;
    end
  end

`ifdef DMEM_WAIT_STATE_EN
  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= 4'(WAIT_CYCLES - 1);
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef DMEM_WAIT_STATE_EN
          state_d = WAIT;
`else
          state_d = RESP;
`endif
        end
      end
      WAIT: begin
`ifdef DMEM_WAIT_STATE_EN
        if (cnt_q == 4'd0) state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed bench for dmem_lsu at XLEN=32 and XLEN=64 side by side
module tb_dmem_lsu;
  localparam int WAIT_CYCLES = 3;
`ifdef DMEM_WAIT_STATE_EN
  localparam int LAT = 1 + WAIT_CYCLES;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dmem_lsu_if #(.XLEN(32), .ADDR_W(12)) i32 ();
  dmem_lsu_if #(.XLEN(64), .ADDR_W(12)) i64 ();

  dmem_lsu #(.XLEN(32), .ADDR_W(12), .WAIT_CYCLES(WAIT_CYCLES)) u32 (.clk(clk), .rst(rst), .bus(i32));
  dmem_lsu #(.XLEN(64), .ADDR_W(12), .WAIT_CYCLES(WAIT_CYCLES)) u64 (.clk(clk), .rst(rst), .bus(i64));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and return at the first cycle rsp_valid is seen (sampled on negedge).
  task automatic txn(input bit w64, input bit we, input logic [1:0] size, input bit uns,
                     input logic [11:0] addr, input logic [63:0] wdata, input bit rr,
                     output logic [63:0] rdata, output logic err);
    int lat;
    @(negedge clk);
    if (w64) begin
      i64.req_we = we; i64.req_size = size; i64.req_unsigned = uns;
      i64.req_addr = addr; i64.req_wdata = wdata; i64.rsp_ready = rr; i64.req_valid = 1'b1;
    end else begin
      i32.req_we = we; i32.req_size = size; i32.req_unsigned = uns;
      i32.req_addr = addr; i32.req_wdata = wdata[31:0]; i32.rsp_ready = rr; i32.req_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    i32.req_valid = 1'b0;
    i64.req_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (w64 ? i64.rsp_valid : i32.rsp_valid) break;
    end
    rdata = w64 ? i64.rsp_rdata : {32'h0, i32.rsp_rdata};
    err   = w64 ? i64.rsp_err : i32.rsp_err;
    check("latency", 64'(lat), 64'(LAT));
  endtask

  logic [63:0] rd;
  logic        er;

  initial begin
    i32.req_valid = 0; i32.req_we = 0; i32.req_size = 0; i32.req_unsigned = 0;
    i32.req_addr = 0; i32.req_wdata = 0; i32.rsp_ready = 1;
    i64.req_valid = 0; i64.req_we = 0; i64.req_size = 0; i64.req_unsigned = 0;
    i64.req_addr = 0; i64.req_wdata = 0; i64.rsp_ready = 1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(i32.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(i32.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(i32.rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(i32.rsp_err),   64'd0);

    txn(0, 1, 2'b10, 0, 12'h010, 64'hDEADBEEF, 1, rd, er);
    check("sw_rdata", rd, 64'h0); check("sw_err", 64'(er), 64'd0);
    txn(0, 0, 2'b10, 0, 12'h010, 64'h0, 1, rd, er);
    check("lw_10", rd, 64'hDEADBEEF); check("lw_10_err", 64'(er), 64'd0);
    txn(0, 0, 2'b00, 1, 12'h013, 64'h0, 1, rd, er);
    check("lbu_13", rd, 64'h000000DE);
    txn(0, 0, 2'b01, 1, 12'h012, 64'h0, 1, rd, er);
    check("lhu_12", rd, 64'h0000DEAD);
    txn(0, 0, 2'b01, 0, 12'h012, 64'h0, 1, rd, er);
    check("lh_12", rd, 64'hFFFFDEAD);

    txn(0, 1, 2'b00, 0, 12'h021, 64'h80, 1, rd, er);
    check("sb_err", 64'(er), 64'd0);
    txn(0, 0, 2'b00, 0, 12'h021, 64'h0, 1, rd, er);
    check("lb_21", rd, 64'hFFFFFF80);
    txn(0, 0, 2'b00, 1, 12'h021, 64'h0, 1, rd, er);
    check("lbu_21", rd, 64'h00000080);
    txn(0, 0, 2'b01, 0, 12'h020, 64'h0, 1, rd, er);
    check("lh_20", rd, 64'hFFFF8000);

    txn(0, 1, 2'b01, 0, 12'h031, 64'h1234, 1, rd, er);
    check("sh_mis_err", 64'(er), 64'd1); check("sh_mis_rdata", rd, 64'h0);
    txn(0, 0, 2'b10, 0, 12'h030, 64'h0, 1, rd, er);
    check("lw_30_nowrite", rd, 64'h0); check("lw_30_err", 64'(er), 64'd0);
    txn(0, 0, 2'b10, 0, 12'h012, 64'h0, 1, rd, er);
    check("lw_mis_err", 64'(er), 64'd1); check("lw_mis_rdata", rd, 64'h0);
    txn(0, 0, 2'b11, 0, 12'h010, 64'h0, 1, rd, er);
    check("ld_x32_err", 64'(er), 64'd1); check("ld_x32_rdata", rd, 64'h0);

    txn(1, 1, 2'b11, 0, 12'h008, 64'h0123456789ABCDEF, 1, rd, er);
    check("sd_err", 64'(er), 64'd0);
    txn(1, 0, 2'b10, 0, 12'h00C, 64'h0, 1, rd, er);
    check("lw64_0c", rd, 64'h0000000001234567);
    txn(1, 0, 2'b10, 0, 12'h008, 64'h0, 1, rd, er);
    check("lw64_08", rd, 64'hFFFFFFFF89ABCDEF);
    txn(1, 0, 2'b10, 1, 12'h008, 64'h0, 1, rd, er);
    check("lwu64_08", rd, 64'h0000000089ABCDEF);
    txn(1, 0, 2'b11, 0, 12'h008, 64'h0, 1, rd, er);
    check("ld64_08", rd, 64'h0123456789ABCDEF); check("ld64_err", 64'(er), 64'd0);
    txn(1, 0, 2'b11, 0, 12'h004, 64'h0, 1, rd, er);
    check("ld64_mis_err", 64'(er), 64'd1); check("ld64_mis_rdata", rd, 64'h0);

    // Back-pressure: response held for 5 cycles while a stray store is offered.
    txn(0, 0, 2'b10, 0, 12'h010, 64'h0, 0, rd, er);
    check("stall_first", rd, 64'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        i32.req_we = 1; i32.req_size = 2'b10; i32.req_addr = 12'h050;
        i32.req_wdata = 32'hCAFEF00D; i32.req_valid = 1'b1;
      end
      if (i == 2) i32.req_valid = 1'b0;
      check("stall_valid", 64'(i32.rsp_valid), 64'd1);
      check("stall_rdata", 64'(i32.rsp_rdata), 64'hDEADBEEF);
      check("stall_err",   64'(i32.rsp_err),   64'd0);
      check("stall_ready", 64'(i32.req_ready), 64'd0);
    end
    i32.rsp_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(i32.rsp_valid), 64'd0);
    check("release_ready", 64'(i32.req_ready), 64'd1);
    txn(0, 0, 2'b10, 0, 12'h050, 64'h0, 1, rd, er);
    check("stray_nowrite", rd, 64'h0);

    // Reset coincident with an accepted store.
    @(negedge clk);
    i32.req_we = 1; i32.req_size = 2'b00; i32.req_addr = 12'h040;
    i32.req_wdata = 32'h55; i32.req_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 i32.req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rstA_valid", 64'(i32.rsp_valid), 64'd0);
    check("rstA_ready", 64'(i32.req_ready), 64'd1);
    txn(0, 0, 2'b00, 0, 12'h040, 64'h0, 1, rd, er);
    check("rstA_nowrite", rd, 64'h0);
    txn(0, 0, 2'b10, 0, 12'h010, 64'h0, 1, rd, er);
    check("rstA_cleared", rd, 64'h0);

    // Reset while a response is pending.
    txn(0, 1, 2'b10, 0, 12'h060, 64'h11223344, 1, rd, er);
    txn(0, 0, 2'b10, 0, 12'h060, 64'h0, 0, rd, er);
    check("rstB_pre", rd, 64'h11223344);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; i32.rsp_ready = 1'b1;
    @(negedge clk);
    check("rstB_valid", 64'(i32.rsp_valid), 64'd0);
    check("rstB_ready", 64'(i32.req_ready), 64'd1);
    check("rstB_rdata", 64'(i32.rsp_rdata), 64'd0);
    txn(0, 0, 2'b10, 0, 12'h060, 64'h0, 1, rd, er);
    check("rstB_cleared", rd, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
